// File: rtl/y86_instr_fetcher.sv
// Byte-serial Y86-64 instruction fetcher: reads one byte per memory transaction, sizes the
// instruction from its icode and hands a 10-byte word to fetch. Optional counters: FETCH_PERF_CNT_EN.
`timescale 1ns/1ps
module y86_instr_fetcher #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   input  logic [63:0] i_req_pc,
   output logic        o_req_ready,
   output logic        o_mem_rd,
   output logic [63:0] o_mem_addr,
   input  logic [7:0]  i_mem_rdata,
   input  logic        i_mem_valid,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   output logic [79:0] o_instr_bytes,
   output logic [3:0]  o_instr_len,
   output logic [63:0] o_valP,
   output logic        o_imem_err,
   output logic        o_instr_invalid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_fetch_count,
   output logic [15:0] o_err_count
`endif
);

   localparam logic [63:0] LIM = 64'(MEM_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_HOLD} state_t;

   state_t      r_state, w_next;
   logic [63:0] r_pc, r_addr;
   logic [3:0]  r_idx, r_len;
   logic [79:0] r_bytes;
   logic        r_err, r_inv;

   logic [3:0]  w_dec_len, w_len;
   logic        w_dec_inv, w_last, w_nx_oob, w_req_oob;
   logic [63:0] w_addr_nx;

   always_comb begin
      w_dec_len = 4'd1;
      w_dec_inv = 1'b0;
      case (i_mem_rdata[7:4])
         4'h0, 4'h1, 4'h9:       w_dec_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: w_dec_len = 4'd2;
         4'h7, 4'h8:             w_dec_len = 4'd9;
         4'h3, 4'h4, 4'h5:       w_dec_len = 4'd10;
         default: begin
            w_dec_len = 4'd1;
            w_dec_inv = 1'b1;
         end
      endcase
   end

   // Length is only known once byte 0 arrives; later bytes use the latched value.
   assign w_len     = (r_idx == 4'd0) ? w_dec_len : r_len;
   assign w_last    = (r_idx + 4'd1) == w_len;
   assign w_addr_nx = r_addr + 64'd1;
   assign w_nx_oob  = w_addr_nx >= LIM;
   assign w_req_oob = i_req_pc >= LIM;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // mem_rd is gated by mem_valid so the data cycle itself is the mandatory idle gap between bytes.
   always_comb begin
      w_next        = r_state;
      o_req_ready   = 1'b0;
      o_mem_rd      = 1'b0;
      o_instr_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_next = w_req_oob ? S_HOLD : S_RD;
         end
         S_RD: begin
            o_mem_rd = ~i_mem_valid;
            if (i_mem_valid && (w_last || w_nx_oob)) w_next = S_HOLD;
         end
         S_HOLD: begin
            o_instr_valid = 1'b1;
            if (i_instr_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc    <= '0;
         r_addr  <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_bytes <= '0;
         r_err   <= 1'b0;
         r_inv   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_req_valid) begin
               r_pc    <= i_req_pc;
               r_addr  <= i_req_pc;
               r_idx   <= '0;
               r_bytes <= '0;
               r_inv   <= 1'b0;
               r_err   <= w_req_oob;
               r_len   <= w_req_oob ? 4'd1 : 4'd0;
            end
            S_RD: if (i_mem_valid) begin
               for (int k = 0; k < 10; k++)
                  if (r_idx == 4'(k)) r_bytes[79-8*k -: 8] <= i_mem_rdata;
               if (r_idx == 4'd0) begin
                  r_len <= w_dec_len;
                  r_inv <= w_dec_inv;
               end
               if (!w_last) begin
                  r_idx  <= r_idx + 4'd1;
                  r_addr <= w_addr_nx;
                  if (w_nx_oob) r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_mem_addr      = r_addr;
   assign o_instr_bytes   = r_bytes;
   assign o_instr_len     = r_len;
   assign o_valP          = r_pc + 64'(r_len);
   assign o_imem_err      = r_err;
   assign o_instr_invalid = r_inv;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_count;
   logic [15:0] r_err_count;
   logic        w_hs;

   assign w_hs = (r_state == S_HOLD) & i_instr_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fetch_count <= '0;
         r_err_count   <= '0;
      end else if (w_hs) begin
         r_fetch_count <= r_fetch_count + 32'd1;
         if ((r_err | r_inv) && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      end
   end

   assign o_fetch_count = r_fetch_count;
   assign o_err_count   = r_err_count;
`endif

endmodule
